spi_request_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one SPI controller between NUM_REQ independent requesters in the PL fabric. Each requester hands over one command word. The block forwards it to the controller's command port, waits for completion or timeout, and returns the received word to the originating requester only. It sits between the requesters and the `spi_controller_interface` and runs on the AXI clock domain.

---
 rtl/spi_arb_pkg.sv | 16 +
 rtl/rr_priority_pick.sv | 38 +++
 rtl/spi_request_arbiter.sv | 163 ++++++++++++++++
 tb/tb_spi_request_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI request arbiter and its round-robin picker.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Grant index width: at least one bit even for tiny requester counts.
  function automatic int unsigned gid_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_priority_pick
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = gid_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!w_found && req[w_cand]) begin
        w_found       = 1'b1;
        grant[w_cand] = 1'b1;
        idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter sharing one SPI controller between NUM_REQ requesters;
// sequences issue, completion/timeout and a one-cycle response to the granted requester.
module spi_request_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [DATA_WIDTH-1:0]         cmd_data,
  input  logic                          spi_done,
  input  logic [DATA_WIDTH-1:0]         spi_rx_data,
  output logic                          busy,
  output logic [gid_width(NUM_REQ)-1:0] grant_id
);

  localparam int unsigned GID_W = gid_width(NUM_REQ);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GID_W-1:0] LAST_ID = GID_W'(NUM_REQ - 1);

  arb_state_t              r_state,     w_state_nxt;
  logic [GID_W-1:0]        r_rr_ptr,    w_rr_ptr_nxt;
  logic [GID_W-1:0]        r_grant_id,  w_grant_id_nxt;
  logic                    r_cmd_valid, w_cmd_valid_nxt;
  logic [DATA_WIDTH-1:0]   r_cmd_data,  w_cmd_data_nxt;
  logic [NUM_REQ-1:0]      r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0]   r_rsp_data,  w_rsp_data_nxt;
  logic                    r_rsp_err,   w_rsp_err_nxt;
  logic                    r_busy,      w_busy_nxt;
  logic [TO_W-1:0]         r_to_cnt,    w_to_cnt_nxt;

  logic [NUM_REQ-1:0]      w_pick_grant;
  logic [GID_W-1:0]        w_pick_idx;
  logic [DATA_WIDTH-1:0]   w_pick_data;
  logic [NUM_REQ-1:0]      w_grant_oh;
  logic                    w_timeout;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_pick_grant),
    .idx   (w_pick_idx)
  );

  always_comb begin
    w_pick_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_pick_idx == GID_W'(i)) begin
        w_pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_grant_oh = NUM_REQ'(1) << r_grant_id;
  // >= rather than == so a handshake landing on the last count still times out in WAIT.
  assign w_timeout  = (r_to_cnt >= TO_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_grant_id_nxt  = r_grant_id;
    w_cmd_valid_nxt = r_cmd_valid;
    w_cmd_data_nxt  = r_cmd_data;
    w_rsp_valid_nxt = '0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_to_cnt_nxt    = r_to_cnt;
    unique case (r_state)
      IDLE: begin
        if (|req_valid) begin
          w_state_nxt     = ISSUE;
          w_grant_id_nxt  = w_pick_idx;
          w_cmd_data_nxt  = w_pick_data;
          w_cmd_valid_nxt = 1'b1;
          w_to_cnt_nxt    = '0;
        end
      end
      ISSUE: begin
        w_to_cnt_nxt = r_to_cnt + 1'b1;
        if (cmd_ready) begin
          w_state_nxt     = WAIT;
          w_cmd_valid_nxt = 1'b0;
        end else if (w_timeout) begin
          w_state_nxt     = RESP;
          w_cmd_valid_nxt = 1'b0;
          w_rsp_valid_nxt = w_grant_oh;
          w_rsp_data_nxt  = '0;
          w_rsp_err_nxt   = 1'b1;
        end
      end
      WAIT: begin
        w_to_cnt_nxt = r_to_cnt + 1'b1;
        if (spi_done) begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = w_grant_oh;
          w_rsp_data_nxt  = spi_rx_data;
          w_rsp_err_nxt   = 1'b0;
        end else if (w_timeout) begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = w_grant_oh;
          w_rsp_data_nxt  = '0;
          w_rsp_err_nxt   = 1'b1;
        end
      end
      RESP: begin
        w_state_nxt  = IDLE;
        w_rr_ptr_nxt = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_cmd_data  <= w_cmd_data_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_busy      <= w_busy_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
    end
  end

  assign req_ready = (r_state == IDLE) ? w_pick_grant : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign cmd_valid = r_cmd_valid;
  assign cmd_data  = r_cmd_data;
  assign busy      = r_busy;
  assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Randomized bench for spi_request_arbiter against a transaction-level reference model.
module tb_spi_request_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 32;
  localparam int TO    = 16;
  localparam int NEVER = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic [DW-1:0]     cmd_data;
  logic              spi_done = 1'b0;
  logic [DW-1:0]     spi_rx_data = '0;
  logic              busy;
  logic [1:0]        grant_id;

  spi_request_arbiter #(
    .NUM_REQ        (NR),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .spi_done     (spi_done),
    .spi_rx_data  (spi_rx_data),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          ptr      = 0;
  logic        pend_v[NR];
  logic [31:0] pend_d[NR];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = pend_v[i];
      req_data[i*DW +: DW]  = pend_d[i];
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < NR; k++) begin
      if (pend_v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  // R: cycle of ISSUE (counted from 0) in which cmd_ready rises; D: cycles from handshake to done.
  task automatic do_txn(input int r, input int d, input logic [31:0] rx, input bit stray, input bit churn);
    int          w, done_at, rc, hs;
    bit          exp_err, exp_cv;
    logic [31:0] ed;
    logic [3:0]  oh;
    drive_reqs();
    #1;
    w = pick();
    if (w < 0) begin
      chk("idle_ready", req_ready, 0);
      chk("idle_busy", busy, 0);
      step();
      return;
    end
    oh = 4'(1) << w;
    chk("req_ready", req_ready, oh);
    ed = pend_d[w];
    step();
    pend_v[w] = 1'b0;
    chk("grant_id", grant_id, w);
    done_at = (r >= NEVER) ? NEVER : r + d;
    exp_err = (done_at > TO - 1);
    rc      = (exp_err ? TO - 1 : done_at) + 1;
    hs      = 0;
    for (int n = 0; n <= rc; n++) begin
      cmd_ready   = (n >= r);
      spi_done    = (n == done_at) || (stray && n == r);
      spi_rx_data = (n == done_at) ? rx : $urandom;
      if (churn) begin
        for (int j = 0; j < NR; j++) begin
          if (j != w && ($urandom % 3) == 0) begin
            pend_v[j] = 1'($urandom % 2);
            pend_d[j] = $urandom;
          end
        end
      end
      drive_reqs();
      #1;
      exp_cv = (r >= NEVER) ? (n < TO) : (n <= r);
      chk("cmd_valid", cmd_valid, exp_cv);
      if (exp_cv) chk("cmd_data", cmd_data, ed);
      chk("busy", busy, 1);
      chk("ready_busy", req_ready, 0);
      chk("rsp_valid", rsp_valid, (n == rc) ? oh : 4'b0);
      if (n == rc) begin
        chk("rsp_data", rsp_data, exp_err ? 32'h0 : rx);
        chk("rsp_err", rsp_err, exp_err);
      end
      if (cmd_valid && cmd_ready) hs++;
      step();
    end
    cmd_ready = 1'b0;
    spi_done  = 1'b0;
    #1;
    chk("post_busy", busy, 0);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_valid", cmd_valid, 0);
    chk("handshakes", hs, (r >= NEVER) ? 0 : 1);
    ptr = (w + 1) % NR;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) pend_v[i] = 1'b0;
    drive_reqs();
    step();
    step();
    rst = 1'b0;
    ptr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int r, d;
    for (int i = 0; i < NR; i++) begin
      pend_v[i] = 1'b0;
      pend_d[i] = '0;
    end
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_data", cmd_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);

    // stray done while idle
    spi_done = 1'b1;
    spi_rx_data = 32'hDEAD_BEEF;
    step();
    spi_done = 1'b0;
    #1;
    chk("stray_busy", busy, 0);
    chk("stray_rsp_valid", rsp_valid, 0);
    chk("stray_cmd_valid", cmd_valid, 0);

    // single request from requester 2
    pend_v[2] = 1'b1;
    pend_d[2] = 32'hA5A5_0001;
    do_txn(0, 10, 32'h1234_5678, 1'b0, 1'b0);

    // fairness: everyone keeps requesting
    do_reset();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend_v[i]) begin
          pend_v[i] = 1'b1;
          pend_d[i] = $urandom;
        end
      end
      do_txn(0, 3, $urandom, 1'b0, 1'b0);
      chk("fair_order", grant_id, k % NR);
    end
    for (int i = 0; i < NR; i++) pend_v[i] = 1'b0;

    // backpressure, completion timeout, issue timeout, coincident done/timeout, stray at handshake
    pend_v[1] = 1'b1; pend_d[1] = $urandom;
    do_txn(5, 4, $urandom, 1'b0, 1'b0);
    pend_v[0] = 1'b1; pend_d[0] = $urandom;
    do_txn(0, NEVER, $urandom, 1'b0, 1'b0);
    pend_v[3] = 1'b1; pend_d[3] = $urandom;
    do_txn(NEVER, NEVER, $urandom, 1'b0, 1'b0);
    pend_v[2] = 1'b1; pend_d[2] = $urandom;
    do_txn(2, 13, 32'hC0FF_EE00, 1'b0, 1'b0);
    pend_v[0] = 1'b1; pend_d[0] = $urandom;
    do_txn(1, 3, $urandom, 1'b1, 1'b1);

    // reset in the middle of WAIT with a non-zero round-robin pointer
    do_reset();
    pend_v[1] = 1'b1; pend_d[1] = $urandom;
    do_txn(0, 3, $urandom, 1'b0, 1'b0);
    pend_v[2] = 1'b1; pend_d[2] = $urandom;
    drive_reqs();
    step();
    pend_v[2] = 1'b0;
    drive_reqs();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_valid", cmd_valid, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_grant_id", grant_id, 0);
    for (int k = 0; k < 3; k++) begin
      spi_done = (k == 1);
      step();
      chk("mid_rst_no_rsp", rsp_valid, 0);
    end
    spi_done = 1'b0;
    rst = 1'b0;
    ptr = 0;
    pend_v[1] = 1'b1; pend_d[1] = $urandom;
    pend_v[3] = 1'b1; pend_d[3] = $urandom;
    do_txn(0, 2, $urandom, 1'b0, 1'b0);
    do_txn(1, 5, $urandom, 1'b0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 50; t++) begin
      for (int j = 0; j < NR; j++) begin
        if (!pend_v[j] && ($urandom % 2) == 1) begin
          pend_v[j] = 1'b1;
          pend_d[j] = $urandom;
        end
      end
      r = (($urandom % 8) == 0) ? NEVER : int'($urandom_range(0, 6));
      d = (($urandom % 6) == 0) ? NEVER : int'($urandom_range(1, 18));
      do_txn(r, d, $urandom, (($urandom % 4) == 0), 1'($urandom % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
